psx_controller: RTL and testbench

//   Device-side (controller-emulation) end of the PSX pad serial link. It answers the host

---
 rtl/psx_controller_pkg.sv | 31 +++
 rtl/psx_controller_if.sv | 11 +
 rtl/psx_controller_sync.sv | 23 ++
 rtl/psx_controller.sv | 157 +++++++++++++++
 tb/tb_psx_controller.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psx_controller_pkg.sv
// Shared protocol constants, FSM state encoding and reply-byte table for the PSX pad link.
package psx_controller_pkg;

    localparam logic [7:0] CMD_START  = 8'h01;
    localparam logic [7:0] CMD_POLL   = 8'h42;
    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] DATA_START = 8'h5A;
    localparam logic [7:0] FILL       = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_DONE,
        ST_IGNORE
    } state_e;

    function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [15:0] snap);
        logic [7:0] r;
        case (idx)
            3'd0:    r = FILL;
            3'd1:    r = ID_DIGITAL;
            3'd2:    r = DATA_START;
            3'd3:    r = snap[7:0];
            default: r = snap[15:8];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/psx_controller_if.sv
// PSX pad serial link: host drives att/psx_clk/cmd, the pad answers on data/ack.
interface psx_controller_if;
    logic att;
    logic psx_clk;
    logic cmd;
    logic data;
    logic ack;

    modport master (output att, output psx_clk, output cmd, input data, input ack);
    modport slave  (input att, input psx_clk, input cmd, output data, output ack);
endinterface

// File: rtl/psx_controller_sync.sv
// Multi-flop synchronizer for one async pin with single-cycle rise/fall pulses.
module psx_controller_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    // The extra top flop holds the previous synced sample for edge detection.
    // Deliberately not reset so a pin held low across rst cannot fake an edge.
    logic [SYNC_STAGES:0] sync_q;
    logic [SYNC_STAGES:0] sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-1:0], din};

    always_ff @(posedge clk) sync_q <= sync_d;

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES];
endmodule

// File: rtl/psx_controller.sv
// Device-side PSX digital pad: answers host polls, pulses ack between bytes, captures motor bytes.
module psx_controller
    import psx_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 4,
    parameter int ACK_WIDTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    psx_controller_if.slave pad,
    input  logic [15:0]     buttons,
    output logic [15:0]     motor,
    output logic            poll_strobe
);
    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic att_rise, att_fall, pclk_rise, pclk_fall, cmd_s;
    logic att_lvl_unused, pclk_lvl_unused, cmd_rise_unused, cmd_fall_unused;

    psx_controller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_att (
        .clk(clk), .din(pad.att), .dout(att_lvl_unused), .rise(att_rise), .fall(att_fall));
    psx_controller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk(clk), .din(pad.psx_clk), .dout(pclk_lvl_unused), .rise(pclk_rise), .fall(pclk_fall));
    psx_controller_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cmd (
        .clk(clk), .din(pad.cmd), .dout(cmd_s), .rise(cmd_rise_unused), .fall(cmd_fall_unused));

    state_e           state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d, byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_q, data_d, ack_q, ack_d, strobe_q, strobe_d;
    logic [15:0]      motor_q, motor_d;
    logic [7:0]       rx_q, rx_d;
    logic [15:0]      snap_q, snap_d, staging_q, staging_d;
    logic [7:0]       rx_byte, reply_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            cnt_q      <= '0;
            data_q     <= 1'b1;
            ack_q      <= 1'b1;
            strobe_q   <= 1'b0;
            motor_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            strobe_q   <= strobe_d;
            motor_q    <= motor_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_q      <= rx_d;
        snap_q    <= snap_d;
        staging_q <= staging_d;
    end

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ack_d      = ack_q;
        strobe_d   = 1'b0;
        motor_d    = motor_q;
        rx_d       = rx_q;
        snap_d     = snap_q;
        staging_d  = staging_q;
        rx_byte    = {cmd_s, rx_q[7:1]};
        reply_cur  = reply_byte(byte_idx_q, snap_q);

        // att release outranks everything, including a psx_clk edge in the same cycle.
        if (att_rise) begin
            state_d = ST_IDLE;
            data_d  = 1'b1;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                    if (att_fall) begin
                        state_d    = ST_SHIFT;
                        bit_idx_d  = '0;
                        byte_idx_d = '0;
                        cnt_d      = '0;
                        snap_d     = buttons;
                    end
                end
                ST_SHIFT: begin
                    if (pclk_fall) begin
                        data_d = reply_cur[bit_idx_q];
                    end else if (pclk_rise) begin
                        rx_d      = rx_byte;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            data_d = 1'b1;
                            cnt_d  = '0;
                            if (byte_idx_q == 3'd3) staging_d[7:0]  = rx_byte;
                            if (byte_idx_q == 3'd4) staging_d[15:8] = rx_byte;
                            if ((byte_idx_q == 3'd0 && rx_byte != CMD_START) ||
                                (byte_idx_q == 3'd1 && rx_byte != CMD_POLL))
                                state_d = ST_IGNORE;
                            else if (byte_idx_q == 3'd4)
                                state_d = ST_DONE;
                            else
                                state_d = ST_ACK_WAIT;
                        end
                    end
                end
                ST_ACK_WAIT: begin
                    if (cnt_q == CNT_W'(ACK_DELAY - 1)) begin
                        state_d = ST_ACK_PULSE;
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACK_PULSE: begin
                    if (cnt_q == CNT_W'(ACK_WIDTH - 1)) begin
                        state_d    = ST_SHIFT;
                        ack_d      = 1'b1;
                        cnt_d      = '0;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    strobe_d = 1'b1;
                    motor_d  = staging_q;
                    state_d  = ST_IGNORE;
                end
                ST_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign pad.data    = data_q;
    assign pad.ack     = ack_q;
    assign motor       = motor_q;
    assign poll_strobe = strobe_q;
endmodule

// File: tb/tb_psx_controller.sv
// Host-side bench for psx_controller: frame-level reference model feeding a scoreboard of monitors.
`timescale 1ns/1ps
module tb_psx_controller;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_DELAY   = 4;
    localparam int ACK_WIDTH   = 2;
    localparam int HP          = 6;   // psx_clk half-period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] buttons;
    logic [15:0] motor;
    logic        poll_strobe;

    psx_controller_if pif();

    psx_controller #(.SYNC_STAGES(SYNC_STAGES), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .clk(clk), .rst(rst), .pad(pif), .buttons(buttons), .motor(motor), .poll_strobe(poll_strobe));

    always #5 clk = ~clk;

    typedef struct {
        int          acks;
        int          strobes;
        logic [15:0] mot;
    } frame_t;

    frame_t      exp_frame_q[$];
    logic [7:0]  exp_data_q[$];
    logic [15:0] exp_strobe_q[$];
    int          checks = 0;
    int          errors = 0;
    int          seen_acks = 0;
    int          seen_strobes = 0;
    logic [15:0] cur_motor = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Data monitor: reassembles each 8-bit reply as the host sees it on psx_clk rises.
    initial begin : data_mon
        int nb;
        logic [7:0] sh;
        logic att_prev;
        nb = 0; sh = 8'h00; att_prev = 1'b1;
        forever begin
            @(pif.att or posedge pif.psx_clk);
            if (pif.att !== att_prev) begin
                att_prev = pif.att;
                nb = 0;
            end else if (pif.att === 1'b0) begin
                sh = {pif.data, sh[7:1]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data_unexpected actual=%0h required=none", sh);
                    end else begin
                        check("data_byte", sh, exp_data_q.pop_front());
                    end
                end
            end
        end
    end

    // Ack / strobe monitor.
    initial begin : ack_mon
        int low;
        low = 0;
        forever begin
            @(negedge clk);
            if (pif.ack === 1'b0) low++;
            else if (low != 0) begin
                check("ack_width", low, ACK_WIDTH);
                seen_acks++;
                low = 0;
            end
            if (poll_strobe === 1'b1) begin
                seen_strobes++;
                if (exp_strobe_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL strobe_unexpected actual=1 required=0");
                end else begin
                    check("strobe_motor", motor, exp_strobe_q.pop_front());
                end
            end
        end
    end

    // Frame monitor: per-frame ack count, strobe count and motor value at att release.
    initial begin : frame_mon
        int a0, s0;
        frame_t f;
        forever begin
            @(negedge pif.att);
            a0 = seen_acks; s0 = seen_strobes;
            @(posedge pif.att);
            if (exp_frame_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_unexpected actual=frame required=none");
            end else begin
                f = exp_frame_q.pop_front();
                check("frame_acks", seen_acks - a0, f.acks);
                check("frame_strobes", seen_strobes - s0, f.strobes);
                check("frame_motor", motor, f.mot);
            end
        end
    end

    // One host frame. cmdv byte k = cmdv[8k+:8]; nbits total bits clocked;
    // buttons switch to btn_mid before byte chg_byte; rst pulses after bit rst_bit's rise.
    task automatic run_frame(input logic [39:0] cmdv, input int nbits, input logic [15:0] btn,
                             input logic [15:0] btn_mid, input int chg_byte, input int rst_bit);
        logic [7:0] rep [5];
        logic [7:0] rb, cb;
        bit         valid;
        bit         exp_ack [5];
        int         acks, strobes, nb, lat, n;
        logic [15:0] mot;

        rep = '{8'hFF, 8'h41, 8'h5A, btn[7:0], btn[15:8]};
        valid = 1'b1; acks = 0; strobes = 0; mot = cur_motor;
        for (int k = 0; k < 5; k++) begin
            exp_ack[k] = 1'b0;
            nb = nbits - 8 * k;
            if (nb > 8) nb = 8;
            if (nb > 0) begin
                rb = valid ? rep[k] : 8'hFF;
                cb = cmdv[8*k +: 8];
                if (rst_bit >= 8 * k && rst_bit < 8 * k + 8) begin
                    for (int i = 0; i < 8; i++) if (8 * k + i > rst_bit) rb[i] = 1'b1;
                    valid = 1'b0;
                    mot = 16'h0000;
                end else if (valid && nb == 8) begin
                    if ((k == 0 && cb != 8'h01) || (k == 1 && cb != 8'h42)) valid = 1'b0;
                    else if (k < 4) begin acks++; exp_ack[k] = 1'b1; end
                    else begin
                        strobes++;
                        mot = {cmdv[39:32], cmdv[31:24]};
                        exp_strobe_q.push_back(mot);
                    end
                end
                if (nb == 8) exp_data_q.push_back(rb);
            end
        end
        exp_frame_q.push_back('{acks, strobes, mot});
        cur_motor = mot;

        buttons = btn;
        @(negedge clk);
        pif.att = 1'b0;
        wait_clks(8);
        for (int k = 0; k < 5; k++) begin
            nb = nbits - 8 * k;
            if (nb > 8) nb = 8;
            if (k == chg_byte) buttons = btn_mid;
            for (int i = 0; i < nb; i++) begin
                cb = cmdv[8*k +: 8];
                pif.psx_clk = 1'b0;
                pif.cmd = cb[i];
                wait_clks(HP);
                pif.psx_clk = 1'b1;
                if (8 * k + i == rst_bit) begin
                    @(negedge clk); rst = 1'b1;
                    @(negedge clk); rst = 1'b0;
                    check("rst_data", pif.data, 1'b1);
                    check("rst_ack", pif.ack, 1'b1);
                    wait_clks(HP - 2);
                end else if (i == 7 && exp_ack[k]) begin
                    lat = 0;
                    while (pif.ack !== 1'b0 && lat < 60) begin @(negedge clk); lat++; end
                    check("ack_latency", lat, SYNC_STAGES + 1 + ACK_DELAY);
                    n = 0;
                    while (pif.ack !== 1'b1 && n < 60) begin @(negedge clk); n++; end
                    if (n >= 60) begin
                        checks++; errors++;
                        $display("FAIL ack_release actual=0 required=1");
                    end
                    wait_clks(2);
                end else begin
                    wait_clks(HP);
                end
            end
            if (nb == 8 && !exp_ack[k]) wait_clks(4);
        end
        wait_clks(4);
        pif.att = 1'b1;
        wait_clks(SYNC_STAGES + 1);
        check("att_rise_data", pif.data, 1'b1);
        check("att_rise_ack", pif.ack, 1'b1);
        wait_clks(10);
    endtask

    initial begin : timeout
        #900000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [39:0] cv;
        logic [15:0] b0, b1;
        int nb, chg;

        rst = 1'b1; pif.att = 1'b1; pif.psx_clk = 1'b1; pif.cmd = 1'b1; buttons = 16'hFFFF;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);
        check("reset_data", pif.data, 1'b1);
        check("reset_ack", pif.ack, 1'b1);
        check("reset_motor", motor, 16'h0000);
        check("reset_strobe", poll_strobe, 1'b0);

        // Full poll
        run_frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h01}, 40, 16'hFFFE, 16'hFFFE, -1, -1);
        // Bad start byte
        run_frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h81}, 40, 16'h1234, 16'h1234, -1, -1);
        // Motor capture, then motor must hold through idle
        run_frame({8'hFF, 8'h00, 8'h00, 8'h42, 8'h01}, 40, 16'hA5C3, 16'hA5C3, -1, -1);
        wait_clks(30);
        check("motor_hold", motor, 16'hFF00);
        // Abort after 13 bits, then a full poll
        run_frame({8'h12, 8'h34, 8'h00, 8'h42, 8'h01}, 13, 16'hFFFF, 16'hFFFF, -1, -1);
        run_frame({8'h5A, 8'hC3, 8'h00, 8'h42, 8'h01}, 40, 16'h0F0F, 16'h0F0F, -1, -1);
        // Button snapshot taken at att fall
        run_frame({8'h00, 8'h00, 8'h00, 8'h42, 8'h01}, 40, 16'hFFFF, 16'h0000, 2, -1);
        // Reset during byte 1, then a full poll must succeed
        run_frame({8'h77, 8'h66, 8'h00, 8'h42, 8'h01}, 40, 16'hBEEF, 16'hBEEF, -1, 9);
        run_frame({8'h81, 8'h18, 8'h00, 8'h42, 8'h01}, 40, 16'hCAFE, 16'hCAFE, -1, -1);

        for (int r = 0; r < 10; r++) begin
            cv[31:0]  = $urandom;
            cv[39:32] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                cv[7:0] = 8'h01;
                cv[15:8] = 8'h42;
            end
            b0 = 16'($urandom_range(0, 65535));
            b1 = 16'($urandom_range(0, 65535));
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 39)) : 40;
            chg = int'($urandom_range(0, 4));
            if (chg == 0) chg = -1;
            run_frame(cv, nb, b0, b1, chg, -1);
        end

        wait_clks(20);
        check("leftover_data", exp_data_q.size(), 0);
        check("leftover_strobe", exp_strobe_q.size(), 0);
        check("leftover_frame", exp_frame_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
